// File: rtl/pipeline_maxmin_frame.sv
// Streaming frame reducer: returns the max or min of each FRAME_LEN-sample frame
// and its position, with valid/ready on both sides and one result of buffering.
module pipeline_maxmin_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4,
  parameter bit SIGNED     = 1'b0,
  parameter int IDX_W      = $clog2(FRAME_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  client_val,
  output logic                  client_rdy,
  input  logic [DATA_WIDTH-1:0] client_data,
  input  logic                  mode_min,
  output logic                  max_val,
  input  logic                  max_rdy,
  output logic [DATA_WIDTH-1:0] max_data,
  output logic [IDX_W-1:0]      max_idx
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  logic [IDX_W-1:0]      cnt, acc_idx, nxt_idx;
  logic [DATA_WIDTH-1:0] acc, nxt_acc;
  logic                  frm_min;
  logic                  last, accept, gt, lt, better;

  assign last = (cnt == LAST);
  // Only the final sample can stall, and only while the output slot is still occupied.
  assign client_rdy = !last || !max_val || max_rdy;
  assign accept     = client_val && client_rdy;

  always_comb begin
    if (SIGNED) begin
      gt = $signed(client_data) > $signed(acc);
      lt = $signed(client_data) < $signed(acc);
    end else begin
      gt = client_data > acc;
      lt = client_data < acc;
    end
    // Strict compare keeps the earliest index on ties; the first sample always seeds.
    better  = (cnt == '0) || (frm_min ? lt : gt);
    nxt_acc = better ? client_data : acc;
    nxt_idx = better ? cnt : acc_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      acc_idx  <= '0;
      frm_min  <= 1'b0;
      max_val  <= 1'b0;
      max_data <= '0;
      max_idx  <= '0;
    end else begin
      if (accept) begin
        cnt     <= last ? '0 : cnt + 1'b1;
        acc     <= nxt_acc;
        acc_idx <= nxt_idx;
        if (cnt == '0) frm_min <= mode_min;
      end
      if (accept && last) begin
        max_data <= nxt_acc;
        max_idx  <= nxt_idx;
        max_val  <= 1'b1;
      end else if (max_rdy) begin
        max_val <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pipeline_maxmin_frame.md
# pipeline_maxmin_frame

Streaming frame reducer: accepts a stream of `DATA_WIDTH`-bit samples over a valid/ready handshake and returns, once per frame of `FRAME_LEN` samples, the frame's maximum or minimum together with its position in the frame. It is the parametrised successor of the single-width pipeline max stage. It adds configurable width, frame length, signed compare, a per-frame max/min mode, index output and full backpressure. It sits between a sample producer (client side) and a result consumer (max side).

## Interface
Parameters:
- `DATA_WIDTH`, 8: sample and result width.
- `FRAME_LEN`, 4: samples per frame; legal values are 2 and above.
- `SIGNED`, 0: 0 = unsigned compare, 1 = two's-complement compare.
- `IDX_W`, `$clog2(FRAME_LEN)`: index width (derived).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `client_val`  in  1  sample valid.
- `client_rdy`  out  1  block can accept a sample.
- `client_data`  in  DATA_WIDTH  sample.
- `mode_min`  in  1  0 = max, 1 = min; sampled with the first sample of each frame.
- `max_val`  out  1  result valid.
- `max_rdy`  in  1  consumer accepts the result.
- `max_data`  out  DATA_WIDTH  frame extreme value.
- `max_idx`  out  IDX_W  position (0-based) of that value in the frame.

## Operation
- Accept means `client_val && client_rdy` on a rising edge. Deliver means `max_val && max_rdy`.
- State registers:
  - `cnt`: IDX_W bits, position of the next sample.
  - `acc`: running extreme.
  - `acc_idx`: position of `acc`.
  - `frm_min`: latched mode.
  - Output register: `max_data`, `max_idx`, `max_val`.
- Accept with `cnt==0`: `acc<=client_data`, `acc_idx<=0`, `frm_min<=mode_min`.
- Accept with `cnt>0`: `acc` and `acc_idx` are replaced by the sample and `cnt` only when the sample is strictly better:
  - greater-than for max mode;
  - less-than for min mode;
  - compare signed iff `SIGNED=1`.
- Ties keep the earliest index.
- `mode_min` changes mid-frame are ignored until the next frame.
- `cnt` increments on every accept and wraps from `FRAME_LEN-1` to 0. Non-power-of-two `FRAME_LEN` wraps explicitly; it never runs to `2^IDX_W`.
- Final accept (`cnt==FRAME_LEN-1`): the output register loads the frame result, including the final sample in the compare, and `max_val<=1`. The running state is free for the next frame in the same cycle.
- `client_rdy = (cnt != FRAME_LEN-1) || !max_val || max_rdy`.
  - Non-final samples are never stalled.
  - The final sample stalls only while an undelivered result occupies the output register.
  - This is combinational in `max_rdy`; it is the only comb path from input to output.
- `max_val` clears on deliver unless a final accept occurs in the same cycle. With a simultaneous final accept it stays 1 and the new result loads.
- `max_data`/`max_idx` are stable while `max_val && !max_rdy`.

## Timing
- Reset: asynchronous assert.
  - Outputs while reset is asserted: `max_val=0`, `max_data=0`, `max_idx=0`, `client_rdy=1`.
  - Internal state: `cnt=0`, `acc=0`, `acc_idx=0`, `frm_min=0`.
- Reset mid-frame discards the partial frame. Reset with `max_val=1` drops the pending result. The first accept after reset starts a new frame at index 0.
- Latency: result visible (`max_val=1`) on the cycle after the final sample's accept edge.
- Throughput: with `client_val=1` and `max_rdy=1` held, one sample per cycle and one result per `FRAME_LEN` cycles, with no bubbles.
- Backpressure depth: one result. At most `FRAME_LEN-1` samples of the next frame are absorbed while the consumer stalls.

## Test plan
- Unsigned max, `FRAME_LEN=4`, `mode_min=0`, samples 3, 250, 7, 250, `max_rdy=1`:
  - required: `max_data=250`, `max_idx=1`;
  - `max_val` high exactly one cycle, starting the cycle after the 4th accept.
- Unsigned min, `mode_min=1` at the first sample and toggled to 0 mid-frame, samples 9, 4, 4, 200:
  - required: `max_data=4`, `max_idx=1` (mode latched, tie keeps earliest).
- `SIGNED=1` instance, samples 0x05, 0xFA, 0x7F, 0x80:
  - max frame: `0x7F`, idx 2;
  - repeat with `mode_min=1`: `0x80`, idx 3.
- Backpressure, `max_rdy=0`, frames {1,2,3,4} then {8,7,6,5}:
  - first result 4/idx 3 holds stable;
  - 8, 7, 6 are accepted;
  - `client_rdy=0` while 5 is offered;
  - raise `max_rdy` for one cycle: 4 is delivered and 5 is accepted on the same edge;
  - next cycle shows 8/idx 0.
- Reset mid-frame: accept 200, 201, assert `rst_n=0` for 2 cycles, then frame 1, 2, 3, 4:
  - during reset `max_val=0` and `max_data=0`;
  - result 4/idx 3 (partial frame discarded).
- Streaming, `client_val=1` and `max_rdy=1` held for 16 cycles, data = cycle count 0..15:
  - `client_rdy` never drops;
  - results 3, 7, 11, 15, each with idx 3, one every 4 cycles.
